debug_bcd_sched: RTL and testbench
==================================

Name: debug_bcd_sched

Overview:
Time-multiplexes one sequential binary-to-BCD converter (double dabble) across the SEQ_NUM signed debug sequences feeding the on-screen debug overlay.
- Once per frame it takes a coherent snapshot of all sequences and converts them in order, slot 0 first.
- It publishes sign plus decimal digits per slot for pixel_gen.
- It sits between the pad_sign-packed debug bus and the pixel generator.

Parameters:
SEQ_LEN, 20, width of each signed two's-complement sequence.
SEQ_NUM, 6, number of sequences sharing the converter.
BCD_DIGITS, 6, decimal magnitude digits per sequence. Must satisfy 10^BCD_DIGITS > 2^(SEQ_LEN-1).
IDX_W, $clog2(SEQ_NUM), slot index width.

Ports:
sys_clk  in  1  system clock; all logic on its rising edge.
sys_rst  in  1  synchronous, active-high reset.
frame_start  in  1  single-cycle pulse at frame boundary (vsync edge), starts a conversion round.
seq_in  in  SEQ_NUM*SEQ_LEN  packed signed sequences; slot k at [k*SEQ_LEN +: SEQ_LEN].
bcd_out  out  SEQ_NUM*BCD_DIGITS*4  packed BCD magnitudes; slot k at [k*BCD_DIGITS*4 +: BCD_DIGITS*4], MS digit highest.
sign_out  out  SEQ_NUM  1 = slot negative.
busy  out  1  round in progress.
done  out  1  one-cycle pulse when the last slot is published.

Behaviour:
- Reset (sys_rst=1 at an edge, regardless of state): bcd_out=0, sign_out=0, busy=0, done=0, state=IDLE, idx=0, shadow=0. Reset mid-round abandons the round; no partial slot is written afterward.
- States: IDLE, LOAD, SHIFT, STORE.
- IDLE:
  - On frame_start, register all of seq_in into the shadow register in the same edge.
  - Set idx=0, go to LOAD. busy=1 from the next cycle.
- LOAD (1 cycle):
  - sign = shadow[idx] MSB.
  - mag = sign ? -value : value, SEQ_LEN bits unsigned. -2^(SEQ_LEN-1) yields 2^(SEQ_LEN-1) correctly.
  - Clear BCD accumulator, bit_cnt=0, go to SHIFT.
- SHIFT (SEQ_LEN cycles):
  - Each cycle, add 3 to every accumulator nibble >=5.
  - Then shift {acc, mag} left by 1.
  - After bit_cnt = SEQ_LEN-1, go to STORE.
- STORE (1 cycle):
  - Write acc into bcd_out slot idx and sign into sign_out[idx]. Write is atomic per slot; other slots unchanged.
  - If idx == SEQ_NUM-1: done=1 for this cycle's registered output, go to IDLE, busy=0 next cycle.
  - Else idx++ and go to LOAD.
- Latency:
  - SEQ_LEN+2 = 22 cycles per slot.
  - With frame_start sampled at edge T, slot k becomes visible after edge T+22*(k+1).
  - done is high in the cycle following edge T+22*SEQ_NUM (T+132); busy is low from then on.
- Zero converts to all-zero digits with sign 0. No negative zero.
- frame_start while busy: ignored. The shadow is not re-sampled and the round continues unaffected.
- frame_start in the same cycle the round ends (STORE of last slot): ignored. It is accepted only in IDLE.
- seq_in changes during a round have no effect on that round.
- Outputs hold their last published values indefinitely between rounds.

Optional Feature:
Macro DEBUG_BCD_SCHED_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt, 8 bits, reset 0.
  - Increments each cycle frame_start=1 while state != IDLE.
  - Saturates at 255; cleared only by sys_rst.
- Undefined: port and counter absent; ignored pulses are silent.

Decomposition:
- Package debug_bcd_sched_pkg holds:
  - state encoding (IDLE=2'd0, LOAD=2'd1, SHIFT=2'd2, STORE=2'd3);
  - default SEQ_LEN/SEQ_NUM/BCD_DIGITS localparams;
  - function for the per-slot packed offsets.
- Sub-module dabble_step is combinational: one add-3 correction plus 1-bit shift over BCD_DIGITS nibbles, instantiated once in SHIFT.

Test Plan:
1. Reset: hold sys_rst=1 for 2 cycles -> bcd_out=0, sign_out=0, busy=0, done=0. Then pulse frame_start with all seq_in=0 -> after 132 cycles done pulses, all slots 0, sign 0.
2. Basic conversion: slot0=20'd12345, slot5=20'd99 -> slot0 bcd=24'h012345 visible after edge T+22; slot5=24'h000099 after edge T+132; done high exactly one cycle.
3. Negative edge values: slot1=20'hFFFFF, slot2=20'h80000, slot3=20'h7FFFF -> sign/bcd respectively 1/24'h000001, 1/24'h524288, 0/24'h524287.
4. Snapshot coherence: frame_start at T with slot4=20'd7, change slot4 to 20'd8 at T+5 -> slot4 publishes 24'h000007. Next round publishes 24'h000008.
5. Overlapping requests: frame_start at T, T+40, T+132 -> only T starts a round; busy continuous T+1..T+132. With macro, drop_cnt=2.
6. Reset mid-round: frame_start at T, sys_rst at T+50 (slots 0-1 already published) -> all outputs 0, IDLE. Next frame_start completes a full 132-cycle round correctly.

Source files
------------

// File: rtl/debug_bcd_sched_pkg.sv
// Shared definitions for the debug overlay BCD scheduler.
// Holds the FSM state encoding, default geometry of the debug bus and the
// helper that computes the bit offset of a slot inside a packed bus.
package debug_bcd_sched_pkg;

  localparam int SEQ_LEN_DEF    = 20;
  localparam int SEQ_NUM_DEF    = 6;
  localparam int BCD_DIGITS_DEF = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    STORE = 2'd3
  } state_t;

  // Bit offset of a slot within a packed bus whose slots are 'width' bits wide.
  function automatic int unsigned slot_ofs(input int unsigned slot, input int unsigned width);
    return slot * width;
  endfunction

endpackage

// File: rtl/debug_bcd_sched_dabble_step.sv
// One double-dabble iteration, purely combinational.
// Every nibble >= 5 gets +3, then the accumulator shifts left by one with
// bit_in entering at the LSB.
// Ports:
//   acc_in  - BCD accumulator before the step
//   bit_in  - next binary bit (MSB first) shifted into the accumulator
//   acc_out - BCD accumulator after correction and shift
module dabble_step
  import debug_bcd_sched_pkg::*;
#(
  parameter int BCD_DIGITS = BCD_DIGITS_DEF
) (
  input  logic [BCD_DIGITS*4-1:0] acc_in,
  input  logic                    bit_in,
  output logic [BCD_DIGITS*4-1:0] acc_out
);

  logic [BCD_DIGITS*4-1:0] corr;

  always_comb begin
    corr = acc_in;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (acc_in[i*4 +: 4] >= 4'd5) corr[i*4 +: 4] = acc_in[i*4 +: 4] + 4'd3;
    end
    acc_out = {corr[BCD_DIGITS*4-2:0], bit_in};
  end

endmodule

// File: rtl/debug_bcd_sched.sv
// Debug overlay BCD scheduler: shares one sequential double-dabble converter
// across SEQ_NUM signed debug values. A frame_start pulse snapshots the whole
// bus, then slots are converted in order and published as sign + magnitude
// digits for the pixel generator.
// Ports:
//   sys_clk     - system clock (rising edge)
//   sys_rst     - synchronous active-high reset
//   frame_start - frame boundary pulse; starts a round when idle
//   seq_in      - packed signed sequences, slot k at [k*SEQ_LEN +: SEQ_LEN]
//   bcd_out     - packed BCD magnitudes, slot k at [k*BCD_DIGITS*4 +: BCD_DIGITS*4]
//   sign_out    - per-slot sign, 1 = negative
//   busy        - round in progress
//   drop_cnt    - saturating count of ignored frame_start pulses
//                 (present only with DEBUG_BCD_SCHED_DROP_CNT_EN defined)
//   done        - one-cycle pulse when the last slot is published
//
// state | meaning
// IDLE  | waiting for frame_start; outputs hold last round
// LOAD  | fetch slot idx from snapshot, split sign/magnitude, clear accumulator
// SHIFT | SEQ_LEN double-dabble iterations
// STORE | publish slot idx, advance or finish the round
module debug_bcd_sched
  import debug_bcd_sched_pkg::*;
#(
  parameter int SEQ_LEN    = SEQ_LEN_DEF,
  parameter int SEQ_NUM    = SEQ_NUM_DEF,
  parameter int BCD_DIGITS = BCD_DIGITS_DEF,
  parameter int IDX_W      = $clog2(SEQ_NUM)
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst,
  input  logic                           frame_start,
  input  logic [SEQ_NUM*SEQ_LEN-1:0]     seq_in,
  output logic [SEQ_NUM*BCD_DIGITS*4-1:0] bcd_out,
  output logic [SEQ_NUM-1:0]             sign_out,
  output logic                           busy,
`ifdef DEBUG_BCD_SCHED_DROP_CNT_EN
  output logic [7:0]                     drop_cnt,
`endif
  output logic                           done
);

  localparam int CNT_W = $clog2(SEQ_LEN);
  localparam int ACC_W = BCD_DIGITS * 4;

  state_t                       state, state_nxt;
  logic [IDX_W-1:0]             idx;
  logic [CNT_W-1:0]             bit_cnt;
  logic [SEQ_NUM*SEQ_LEN-1:0]   shadow;
  logic [SEQ_LEN-1:0]           cur_val;
  logic [SEQ_LEN-1:0]           mag;
  logic                         sign_r;
  logic [ACC_W-1:0]             acc;
  logic [ACC_W-1:0]             acc_step;
  logic                         last_bit;
  logic                         last_slot;

  assign cur_val   = shadow[slot_ofs(32'(idx), SEQ_LEN) +: SEQ_LEN];
  assign last_bit  = (bit_cnt == CNT_W'(SEQ_LEN - 1));
  assign last_slot = (idx == IDX_W'(SEQ_NUM - 1));

  dabble_step #(.BCD_DIGITS(BCD_DIGITS)) u_step (
    .acc_in (acc),
    .bit_in (mag[SEQ_LEN-1]),
    .acc_out(acc_step)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_start) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = STORE;
      STORE:   state_nxt = last_slot ? IDLE : LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      shadow   <= '0;
      idx      <= '0;
      bit_cnt  <= '0;
      mag      <= '0;
      sign_r   <= 1'b0;
      acc      <= '0;
      bcd_out  <= '0;
      sign_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            shadow <= seq_in;
            idx    <= '0;
            busy   <= 1'b1;
          end
        end
        LOAD: begin
          // Two's-complement negate keeps -2^(SEQ_LEN-1) as the correct unsigned magnitude.
          sign_r  <= cur_val[SEQ_LEN-1];
          mag     <= cur_val[SEQ_LEN-1] ? (~cur_val + SEQ_LEN'(1)) : cur_val;
          acc     <= '0;
          bit_cnt <= '0;
        end
        SHIFT: begin
          acc     <= acc_step;
          mag     <= mag << 1;
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
        STORE: begin
          bcd_out[slot_ofs(32'(idx), ACC_W) +: ACC_W] <= acc;
          sign_out[idx] <= sign_r;
          if (last_slot) begin
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DEBUG_BCD_SCHED_DROP_CNT_EN
  always_ff @(posedge sys_clk) begin
    if (sys_rst)                                          drop_cnt <= 8'd0;
    else if (frame_start && state != IDLE && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_debug_bcd_sched.sv
module tb_debug_bcd_sched;
  import debug_bcd_sched_pkg::*;

  localparam int L = SEQ_LEN_DEF;
  localparam int N = SEQ_NUM_DEF;
  localparam int D = BCD_DIGITS_DEF;
  localparam int SLOT_LAT = L + 2;

  logic               sys_clk = 1'b0;
  logic               sys_rst = 1'b1;
  logic               frame_start = 1'b0;
  logic [N*L-1:0]     seq_in = '0;
  logic [N*D*4-1:0]   bcd_out;
  logic [N-1:0]       sign_out;
  logic               busy;
  logic               done;
`ifdef DEBUG_BCD_SCHED_DROP_CNT_EN
  logic [7:0]         drop_cnt;
`endif

  debug_bcd_sched dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .frame_start(frame_start),
    .seq_in     (seq_in),
    .bcd_out    (bcd_out),
    .sign_out   (sign_out),
    .busy       (busy),
`ifdef DEBUG_BCD_SCHED_DROP_CNT_EN
    .drop_cnt   (drop_cnt),
`endif
    .done       (done)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reference model state: expected outputs after each rising edge.
  bit             active = 1'b0;
  int             n_since = 0;
  logic [L-1:0]   snap [N];
  logic [D*4-1:0] exp_bcd [N];
  logic           exp_sign [N];
  logic           exp_busy = 1'b0;
  logic           exp_done = 1'b0;
  int             exp_drop = 0;

  function automatic logic [D*4-1:0] to_bcd(input logic [L-1:0] v);
    longint m;
    logic [D*4-1:0] r;
    m = longint'($signed(v));
    if (m < 0) m = -m;
    r = '0;
    for (int i = 0; i < D; i++) begin
      r[i*4 +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge sys_clk);
      if (sys_rst) begin
        active = 1'b0; n_since = 0;
        for (int k = 0; k < N; k++) begin exp_bcd[k] = '0; exp_sign[k] = 1'b0; snap[k] = '0; end
        exp_busy = 1'b0; exp_done = 1'b0; exp_drop = 0;
      end else begin
        exp_done = 1'b0;
        if (active) begin
          if (frame_start && exp_drop < 255) exp_drop++;
          n_since++;
          for (int k = 0; k < N; k++) begin
            if (n_since == SLOT_LAT*(k+1)) begin
              exp_bcd[k]  = to_bcd(snap[k]);
              exp_sign[k] = snap[k][L-1];
            end
          end
          if (n_since == SLOT_LAT*N) begin
            exp_done = 1'b1; exp_busy = 1'b0; active = 1'b0;
          end
        end else if (frame_start) begin
          active = 1'b1; n_since = 0; exp_busy = 1'b1;
          for (int k = 0; k < N; k++) snap[k] = seq_in[k*L +: L];
        end
      end
    end
  end

  initial begin
    logic [N*D*4-1:0] eb;
    logic [N-1:0]     es;
    forever begin
      @(negedge sys_clk);
      if (cmp_en) begin
        for (int k = 0; k < N; k++) begin
          eb[k*D*4 +: D*4] = exp_bcd[k];
          es[k] = exp_sign[k];
        end
        chk("bcd_out", bcd_out, eb);
        chk("sign_out", sign_out, es);
        chk("busy", busy, exp_busy);
        chk("done", done, exp_done);
`ifdef DEBUG_BCD_SCHED_DROP_CNT_EN
        chk("drop_cnt", drop_cnt, exp_drop);
`endif
      end
    end
  end

  task automatic tick(input int c);
    repeat (c) @(negedge sys_clk);
  endtask

  task automatic pulse();
    frame_start = 1'b1;
    @(negedge sys_clk);
    frame_start = 1'b0;
  endtask

  task automatic set_slot(input int k, input logic [L-1:0] v);
    seq_in[k*L +: L] = v;
  endtask

  function automatic logic [L-1:0] rand_val();
    case ($urandom_range(0, 5))
      0:       return 20'h80000;
      1:       return 20'h7FFFF;
      2:       return 20'h00000;
      3:       return 20'hFFFFF;
      default: return L'($urandom);
    endcase
  endfunction

  initial begin
    int dcnt;
    // 1. reset
    sys_rst = 1'b1;
    @(posedge sys_clk);
    cmp_en = 1'b1;
    tick(2);
    sys_rst = 1'b0;
    chk("rst_bcd", bcd_out, '0);
    chk("rst_sign", sign_out, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    seq_in = '0;
    pulse();
    tick(140);
    chk("zero_bcd", bcd_out, '0);

    // 2. basic conversion, done is a single-cycle pulse
    set_slot(0, 20'd12345);
    set_slot(5, 20'd99);
    pulse();
    dcnt = 0;
    for (int i = 0; i < 140; i++) begin
      @(negedge sys_clk);
      if (done === 1'b1) dcnt++;
    end
    chk("done_pulses", dcnt, 1);
    chk("slot0_12345", bcd_out[0 +: 24], 24'h012345);
    chk("slot5_99", bcd_out[5*24 +: 24], 24'h000099);

    // 3. negative and extreme values
    set_slot(1, 20'hFFFFF);
    set_slot(2, 20'h80000);
    set_slot(3, 20'h7FFFF);
    pulse();
    tick(140);
    chk("slot1_bcd", bcd_out[1*24 +: 24], 24'h000001);
    chk("slot1_sign", sign_out[1], 1'b1);
    chk("slot2_bcd", bcd_out[2*24 +: 24], 24'h524288);
    chk("slot2_sign", sign_out[2], 1'b1);
    chk("slot3_bcd", bcd_out[3*24 +: 24], 24'h524287);
    chk("slot3_sign", sign_out[3], 1'b0);

    // 4. snapshot coherence
    set_slot(4, 20'd7);
    pulse();
    tick(4);
    set_slot(4, 20'd8);
    tick(140);
    chk("snap_slot4_7", bcd_out[4*24 +: 24], 24'h000007);
    pulse();
    tick(140);
    chk("snap_slot4_8", bcd_out[4*24 +: 24], 24'h000008);

    // 5. overlapping requests at T, T+40, T+132
    pulse();
    tick(39);
    pulse();
    tick(91);
    pulse();
    chk("ovl_busy_idle", busy, 1'b0);
    tick(20);
    chk("ovl_still_idle", busy, 1'b0);
`ifdef DEBUG_BCD_SCHED_DROP_CNT_EN
    chk("ovl_drop_cnt", drop_cnt, 8'd2);
`endif

    // 6. reset mid-round
    for (int k = 0; k < N; k++) set_slot(k, rand_val());
    pulse();
    tick(49);
    sys_rst = 1'b1;
    tick(1);
    sys_rst = 1'b0;
    chk("midrst_bcd", bcd_out, '0);
    chk("midrst_busy", busy, 1'b0);
    tick(30);
    chk("midrst_stays0", bcd_out, '0);
    for (int k = 0; k < N; k++) set_slot(k, rand_val());
    pulse();
    tick(140);

    // Randomized rounds with stray pulses and bus changes mid-round
    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < N; k++) set_slot(k, rand_val());
      pulse();
      for (int c = 0; c < 132 + int'($urandom_range(0, 20)); c++) begin
        if ($urandom_range(0, 9) == 0) set_slot(int'($urandom_range(0, N-1)), rand_val());
        frame_start = ($urandom_range(0, 15) == 0);
        @(negedge sys_clk);
        frame_start = 1'b0;
      end
      tick(3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
